// File: rtl/long_arith_sequencer_pkg.sv
// Shared types for the long-arithmetic sequencer: op/state/Alu-oper enums,
// flag bit positions and the 64-bit operand width helper.
package long_arith_sequencer_pkg;

  localparam int CPU_WORD_WIDTH = 32;

  // Flag vector is {N, Z, C, V}
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic {
    LongSeq_Add = 1'b0,
    LongSeq_Sub = 1'b1
  } long_seq_op_e;

  typedef enum logic [1:0] {
    LongSeq_Idle,
    LongSeq_Lo,
    LongSeq_Hi,
    LongSeq_Done
  } long_seq_state_e;

  typedef enum logic [1:0] {
    Alu_Add,
    Alu_Sub,
    Alu_Adc,
    Alu_Sbc
  } alu_oper_e;

  typedef struct packed {
    long_seq_op_e op;
    logic         use_carry;
    logic [3:0]   flags;
  } req_ctl_t;

  function automatic int long_arithlog_operand_msb_pos(input int word_width);
    return 2 * word_width - 1;
  endfunction

endpackage

// File: rtl/long_arith_sequencer.sv
// Runs a double-word add/sub as two passes through a shared, arbitrated Alu
// (low word then high word) and merges the per-word flags into 64-bit NZCV.
module long_arith_sequencer
  import long_arith_sequencer_pkg::*;
#(
  parameter int WORD_WIDTH = CPU_WORD_WIDTH
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               req_valid,
  output logic                                               req_ready,
  input  long_seq_op_e                                       req_op,
  input  logic                                               req_use_carry,
  input  logic [3:0]                                         req_flags,
  input  logic [long_arithlog_operand_msb_pos(WORD_WIDTH):0] req_a,
  input  logic [long_arithlog_operand_msb_pos(WORD_WIDTH):0] req_b,
  output logic                                               alu_req,
  input  logic                                               alu_gnt,
  output alu_oper_e                                          alu_oper,
  output logic [WORD_WIDTH-1:0]                              alu_a,
  output logic [WORD_WIDTH-1:0]                              alu_b,
  output logic [3:0]                                         alu_flags_in,
  input  logic [WORD_WIDTH-1:0]                              alu_result,
  input  logic [3:0]                                         alu_flags,
  output logic                                               rsp_valid,
  input  logic                                               rsp_ready,
  output logic [long_arithlog_operand_msb_pos(WORD_WIDTH):0] rsp_result,
  output logic [3:0]                                         rsp_flags
);

  localparam int OP_MSB = long_arithlog_operand_msb_pos(WORD_WIDTH);

  long_seq_state_e        state, state_nxt;
  req_ctl_t               ctl_q;
  logic [OP_MSB:0]        a_q, b_q, result_q;
  logic [WORD_WIDTH-1:0]  lo_q;
  logic                   c_lo_q, z_lo_q;
  logic [3:0]             flags_q;
  logic [3:0]             hi_flags_in;
  logic [3:0]             merged_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LongSeq_Idle;
    else        state <= state_nxt;
  end

  // High pass reuses the caller's flags but chains the low-word carry.
  always_comb begin
    hi_flags_in         = ctl_q.flags;
    hi_flags_in[FLAG_C] = c_lo_q;
  end

  always_comb begin
    merged_flags         = '0;
    merged_flags[FLAG_N] = alu_flags[FLAG_N];
    merged_flags[FLAG_Z] = z_lo_q & alu_flags[FLAG_Z];
    merged_flags[FLAG_C] = alu_flags[FLAG_C];
    merged_flags[FLAG_V] = alu_flags[FLAG_V];
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    alu_req      = 1'b0;
    alu_oper     = Alu_Add;
    alu_a        = '0;
    alu_b        = '0;
    alu_flags_in = '0;
    rsp_valid    = 1'b0;
    case (state)
      LongSeq_Idle: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = LongSeq_Lo;
      end
      LongSeq_Lo: begin
        alu_req      = 1'b1;
        alu_a        = a_q[WORD_WIDTH-1:0];
        alu_b        = b_q[WORD_WIDTH-1:0];
        alu_flags_in = ctl_q.flags;
        if (ctl_q.use_carry) alu_oper = (ctl_q.op == LongSeq_Sub) ? Alu_Sbc : Alu_Adc;
        else                 alu_oper = (ctl_q.op == LongSeq_Sub) ? Alu_Sub : Alu_Add;
        if (alu_gnt) state_nxt = LongSeq_Hi;
      end
      LongSeq_Hi: begin
        alu_req      = 1'b1;
        alu_a        = a_q[OP_MSB:WORD_WIDTH];
        alu_b        = b_q[OP_MSB:WORD_WIDTH];
        alu_flags_in = hi_flags_in;
        alu_oper     = (ctl_q.op == LongSeq_Sub) ? Alu_Sbc : Alu_Adc;
        if (alu_gnt) state_nxt = LongSeq_Done;
      end
      LongSeq_Done: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = LongSeq_Idle;
      end
      default: state_nxt = LongSeq_Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      lo_q     <= '0;
      c_lo_q   <= 1'b0;
      z_lo_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (state == LongSeq_Idle && req_valid) begin
        ctl_q <= '{op: req_op, use_carry: req_use_carry, flags: req_flags};
        a_q   <= req_a;
        b_q   <= req_b;
      end
      if (state == LongSeq_Lo && alu_gnt) begin
        lo_q   <= alu_result;
        c_lo_q <= alu_flags[FLAG_C];
        z_lo_q <= alu_flags[FLAG_Z];
      end
      if (state == LongSeq_Hi && alu_gnt) begin
        result_q <= {alu_result, lo_q};
        flags_q  <= merged_flags;
      end
    end
  end

  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_long_arith_sequencer.sv
// Directed bench for long_arith_sequencer with a behavioural 32-bit Alu
// standing in for the shared execute Alu.
module tb_long_arith_sequencer;
  import long_arith_sequencer_pkg::*;

  logic         clk, rst_n;
  logic         req_valid, req_ready, req_use_carry;
  long_seq_op_e req_op;
  logic [3:0]   req_flags;
  logic [63:0]  req_a, req_b;
  logic         alu_req, alu_gnt;
  alu_oper_e    alu_oper;
  logic [31:0]  alu_a, alu_b, alu_result;
  logic [3:0]   alu_flags_in, alu_flags;
  logic         rsp_valid, rsp_ready;
  logic [63:0]  rsp_result;
  logic [3:0]   rsp_flags;

  int checks;
  int failures;

  long_arith_sequencer #(.WORD_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_use_carry(req_use_carry), .req_flags(req_flags),
    .req_a(req_a), .req_b(req_b),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_oper(alu_oper),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Alu: a + b (+cin) for add forms, a + ~b (+cin) for subtract forms.
  logic [32:0] alu_sum;
  logic [31:0] alu_bop;
  logic        alu_cin;
  always_comb begin
    alu_bop = alu_b;
    alu_cin = 1'b0;
    case (alu_oper)
      Alu_Add: begin alu_bop = alu_b;  alu_cin = 1'b0; end
      Alu_Sub: begin alu_bop = ~alu_b; alu_cin = 1'b1; end
      Alu_Adc: begin alu_bop = alu_b;  alu_cin = alu_flags_in[FLAG_C]; end
      Alu_Sbc: begin alu_bop = ~alu_b; alu_cin = alu_flags_in[FLAG_C]; end
      default: ;
    endcase
    alu_sum    = {1'b0, alu_a} + {1'b0, alu_bop} + {32'd0, alu_cin};
    alu_result = alu_sum[31:0];
    alu_flags          = '0;
    alu_flags[FLAG_N]  = alu_sum[31];
    alu_flags[FLAG_Z]  = (alu_sum[31:0] == 32'd0);
    alu_flags[FLAG_C]  = alu_sum[32];
    alu_flags[FLAG_V]  = (alu_a[31] == alu_bop[31]) && (alu_sum[31] != alu_a[31]);
  end

  // Drives one request with immediate grants and collects what the Alu saw.
  task automatic do_op(input long_seq_op_e op, input logic uc, input logic [3:0] fl,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic [3:0] rfl, output int lat,
                       output alu_oper_e lo_op, output alu_oper_e hi_op,
                       output logic lo_cin, output logic hi_cin);
    int g;
    g = 0; lo_op = Alu_Add; hi_op = Alu_Add; lo_cin = 1'b0; hi_cin = 1'b0;
    alu_gnt = 1'b1;
    req_op = op; req_use_carry = uc; req_flags = fl; req_a = a; req_b = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      if (alu_req && alu_gnt) begin
        if (g == 0) begin lo_op = alu_oper; lo_cin = alu_flags_in[FLAG_C]; end
        else        begin hi_op = alu_oper; hi_cin = alu_flags_in[FLAG_C]; end
        g++;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = rsp_result;
    rfl = rsp_flags;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({req_ready, alu_req, rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctl got ready/req/valid=%b want 100", {req_ready, alu_req, rsp_valid});
    end
    checks++;
    if (rsp_result !== 64'd0 || rsp_flags !== 4'd0) begin
      failures++;
      $display("FAIL reset_rsp got %h/%h want 0/0", rsp_result, rsp_flags);
    end
    checks++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_flags_in !== 4'd0 || alu_oper !== Alu_Add) begin
      failures++;
      $display("FAIL reset_alu got a=%h b=%h f=%h op=%0d want 0 0 0 Add", alu_a, alu_b, alu_flags_in, alu_oper);
    end
  endtask

  task automatic test_add_carry();
    logic [63:0] r; logic [3:0] f; int lat; alu_oper_e lo, hi; logic lc, hc;
    do_op(LongSeq_Add, 1'b0, 4'h0, 64'h0000_0000_FFFF_FFFF, 64'h1, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'h0000_0001_0000_0000 || f !== 4'b0000) begin
      failures++;
      $display("FAIL add_carry got %h/%b want 0000000100000000/0000", r, f);
    end
    checks++;
    if (lo !== Alu_Add || hi !== Alu_Adc || hc !== 1'b1) begin
      failures++;
      $display("FAIL add_carry_alu got lo=%0d hi=%0d cin=%b want Add Adc 1", lo, hi, hc);
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL add_latency got %0d want 3", lat);
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_return_idle got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_sub_borrow();
    logic [63:0] r; logic [3:0] f; int lat; alu_oper_e lo, hi; logic lc, hc;
    do_op(LongSeq_Sub, 1'b0, 4'h0, 64'h0000_0001_0000_0000, 64'h1, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'h0000_0000_FFFF_FFFF || f !== 4'b0010) begin
      failures++;
      $display("FAIL sub_borrow got %h/%b want 00000000ffffffff/0010", r, f);
    end
    checks++;
    if (lo !== Alu_Sub || hi !== Alu_Sbc || hc !== 1'b0 || lat !== 3) begin
      failures++;
      $display("FAIL sub_alu got lo=%0d hi=%0d cin=%b lat=%0d want Sub Sbc 0 3", lo, hi, hc, lat);
    end
  endtask

  task automatic test_zero_merge();
    logic [63:0] r; logic [3:0] f; int lat; alu_oper_e lo, hi; logic lc, hc;
    do_op(LongSeq_Add, 1'b0, 4'h0, 64'hFFFF_FFFF_0000_0001, 64'h0000_0000_FFFF_FFFF, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'd0 || f !== 4'b0110) begin
      failures++;
      $display("FAIL zero_both got %h/%b want 0/0110", r, f);
    end
    do_op(LongSeq_Add, 1'b0, 4'h0, 64'h0000_0001_0000_0000, 64'h0, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'h0000_0001_0000_0000 || f !== 4'b0000) begin
      failures++;
      $display("FAIL zero_lo_only got %h/%b want 0000000100000000/0000", r, f);
    end
  endtask

  task automatic test_overflow_chain();
    logic [63:0] r; logic [3:0] f; int lat; alu_oper_e lo, hi; logic lc, hc;
    do_op(LongSeq_Add, 1'b0, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || f !== 4'b1001) begin
      failures++;
      $display("FAIL overflow got %h/%b want 8000000000000000/1001", r, f);
    end
    do_op(LongSeq_Add, 1'b1, 4'b0010, 64'h0, 64'h0, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'd1 || f !== 4'b0000) begin
      failures++;
      $display("FAIL chain got %h/%b want 1/0000", r, f);
    end
    checks++;
    if (lo !== Alu_Adc || lc !== 1'b1 || hi !== Alu_Adc) begin
      failures++;
      $display("FAIL chain_alu got lo=%0d cin=%b hi=%0d want Adc 1 Adc", lo, lc, hi);
    end
  endtask

  task automatic test_alu_stall();
    logic [69:0] snap;
    int n;
    req_op = LongSeq_Add; req_use_carry = 1'b0; req_flags = 4'h0;
    req_a = 64'h0000_0000_FFFF_FFFF; req_b = 64'h1;
    alu_gnt = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; n = 1;
    snap = {alu_oper, alu_a, alu_b, alu_flags_in};
    checks++;
    if (snap !== {Alu_Add, 32'hFFFF_FFFF, 32'h1, 4'h0}) begin
      failures++;
      $display("FAIL stall_lo_drive got %h want Add/ffffffff/1/0", snap);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (alu_req !== 1'b1 || {alu_oper, alu_a, alu_b, alu_flags_in} !== snap) begin
        failures++;
        $display("FAIL stall_lo_hold cyc=%0d got req=%b %h want 1 %h", i, alu_req,
                 {alu_oper, alu_a, alu_b, alu_flags_in}, snap);
      end
      @(posedge clk); #1; n++;
    end
    alu_gnt = 1'b1;
    @(posedge clk); #1; n++;
    alu_gnt = 1'b0;
    snap = {alu_oper, alu_a, alu_b, alu_flags_in};
    checks++;
    if (snap !== {Alu_Adc, 32'h0, 32'h0, 4'b0010}) begin
      failures++;
      $display("FAIL stall_hi_drive got %h want Adc/0/0/2", snap);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; n++;
      checks++;
      if (alu_req !== 1'b1 || {alu_oper, alu_a, alu_b, alu_flags_in} !== snap || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hi_hold cyc=%0d got req=%b vld=%b %h want 1 0 %h", i, alu_req, rsp_valid,
                 {alu_oper, alu_a, alu_b, alu_flags_in}, snap);
      end
    end
    alu_gnt = 1'b1;
    @(posedge clk); #1; n++;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'h0000_0001_0000_0000 || rsp_flags !== 4'b0000 || n !== 11) begin
      failures++;
      $display("FAIL stall_result got vld=%b %h/%b lat=%0d want 1 0000000100000000/0000 11",
               rsp_valid, rsp_result, rsp_flags, n);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    alu_gnt = 1'b1;
    req_op = LongSeq_Add; req_use_carry = 1'b0; req_flags = 4'h0;
    req_a = 64'd100; req_b = 64'd200; req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = 64'd10; req_b = 64'd20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 64'd300 || req_ready !== 1'b0 || alu_req !== 1'b0) begin
        failures++;
        $display("FAIL rsp_hold cyc=%0d got vld=%b res=%h rdy=%b areq=%b want 1 12c 0 0", i,
                 rsp_valid, rsp_result, req_ready, alu_req);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || alu_req !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_no_accept got rdy=%b areq=%b vld=%b want 1 0 0", req_ready, alu_req, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 64'd30) begin
      failures++;
      $display("FAIL pending_req got vld=%b res=%h want 1 1e", rsp_valid, rsp_result);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hi();
    logic [63:0] r; logic [3:0] f; int lat; alu_oper_e lo, hi; logic lc, hc;
    int seen;
    alu_gnt = 1'b1;
    req_op = LongSeq_Sub; req_use_carry = 1'b0; req_flags = 4'h0;
    req_a = 64'h0000_0005_0000_0009; req_b = 64'h0000_0001_0000_0002; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    alu_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, alu_req, rsp_valid} !== 3'b100 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
        alu_oper !== Alu_Add || alu_flags_in !== 4'd0 || rsp_result !== 64'd0 || rsp_flags !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got rdy/req/vld=%b a=%h b=%h op=%0d res=%h want 100 0 0 Add 0",
               {req_ready, alu_req, rsp_valid}, alu_a, alu_b, alu_oper, rsp_result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    alu_gnt = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL post_reset_idle got %0d bad cycles want 0", seen);
    end
    do_op(LongSeq_Add, 1'b0, 4'h0, 64'd2, 64'd3, r, f, lat, lo, hi, lc, hc);
    checks++;
    if (r !== 64'd5 || f !== 4'b0000 || lat !== 3) begin
      failures++;
      $display("FAIL fresh_add got %h/%b lat=%0d want 5/0000 3", r, f, lat);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1;
    req_valid = 1'b0; req_op = LongSeq_Add; req_use_carry = 1'b0; req_flags = 4'h0;
    req_a = '0; req_b = '0; alu_gnt = 1'b0; rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_carry();
    test_sub_borrow();
    test_zero_merge();
    test_overflow_chain();
    test_alu_stall();
    test_rsp_backpressure();
    test_reset_mid_hi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
